// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg -- shared definitions for the instruction fetch unit.
//   state_t        : fetch FSM state encoding (also exported for debug)
//   XLEN_DEF       : default fetch data / bus data width
//   ADDR_W_DEF     : default instruction address width
//   LINE_OFF_W     : byte-offset bits inside one fetch line (8-byte lines)
//   PC_RESET       : architectural reset fetch address
// Optional feature macro used by the fetch unit: IFU_LINE_CACHE_EN.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam int XLEN_DEF   = 64;
  localparam int ADDR_W_DEF = 64;
  localparam int LINE_OFF_W = 3;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ifu_line_hold.sv
// ifu_line_hold -- one-entry store of the last delivered fetch line.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : invalidate the held line (reset or fence.i)
//   upd           : capture upd_addr/upd_data as the new held line
//   lookup_addr   : aligned line address being fetched this cycle
//   hit, hit_data : held line matches lookup_addr, and its data
//   held_valid    : the held line is valid (debug visibility)
module ifu_line_hold #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              upd,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [XLEN-1:0]   upd_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [XLEN-1:0]   hit_data,
  output logic              held_valid
);

  logic [ADDR_W-1:0] held_addr;
  logic [XLEN-1:0]   held_data;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      held_valid <= 1'b0;
      held_addr  <= '0;
      held_data  <= '0;
    end else if (upd) begin
      held_valid <= 1'b1;
      held_addr  <= upd_addr;
      held_data  <= upd_data;
    end
  end

  assign hit      = held_valid && (held_addr == lookup_addr);
  assign hit_data = held_data;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit between the instruction buffer and
// the instruction bus. One request outstanding at most.
//   clk, rstn        : clock, synchronous ACTIVE-HIGH reset (1 = in reset)
//   fencei_flush     : drop in-flight and held fetch data
//   fetch_addr       : requested line address (bits [2:0] ignored)
//   fetch_data/valid : line data for the current fetch_addr, same cycle
//   ibus_req/addr    : bus read request; accepted when ibus_gnt is also 1
//   ibus_rvalid/rdata: in-order read response, one per accepted request
//   fsm_state        : current FSM state (debug)
// Handshake: a request transfers in a cycle with ibus_req && ibus_gnt; the
// bus answers each transfer with exactly one ibus_rvalid cycle, in order.
// Macro IFU_LINE_CACHE_EN adds a one-line hold (ifu_line_hold) that serves
// repeat fetches of the last delivered line without a bus request.
module ifu_fetch import ifu_fetch_pkg::*; #(
  parameter int XLEN   = XLEN_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fencei_flush,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [XLEN-1:0]   fetch_data,
  output logic              fetch_valid,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_gnt,
  input  logic              ibus_rvalid,
  input  logic [XLEN-1:0]   ibus_rdata,
  output state_t            fsm_state
);

  state_t            state;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] aligned;
  logic              hit;
  logic [XLEN-1:0]   hit_data;
  logic              deliver;
  logic              hold_serve;
  logic              unused_offset;

  assign aligned       = {fetch_addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign unused_offset = ^fetch_addr[LINE_OFF_W-1:0];

`ifdef IFU_LINE_CACHE_EN
  logic held_valid;

  ifu_line_hold #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_hold (
    .clk         (clk),
    .rst         (rstn),
    .clear       (fencei_flush),
    .upd         (deliver),
    .upd_addr    (req_line),
    .upd_data    (ibus_rdata),
    .lookup_addr (aligned),
    .hit         (hit),
    .hit_data    (hit_data),
    .held_valid  (held_valid)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // A response is delivered only if it is for the line asked for right now.
  assign deliver    = !rstn && !fencei_flush && (state == S_WAIT) &&
                      ibus_rvalid && (req_line == aligned);
  assign hold_serve = !rstn && !fencei_flush && hit;

  assign fetch_valid = deliver || hold_serve;
  assign fetch_data  = deliver    ? ibus_rdata :
                       hold_serve ? hit_data   : '0;

  // In REQ the request tracks fetch_addr combinationally so that the first
  // request after a delivery already carries the new line (no bubble);
  // req_line captures the same value each cycle, holding it from grant on.
  assign ibus_req  = !rstn && !fencei_flush && (state == S_REQ) && !hit;
  assign ibus_addr = rstn ? '0 : ((state == S_REQ) ? aligned : req_line);

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= S_IDLE;
      req_line <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fencei_flush && !hit) begin
            req_line <= aligned;
            state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (fencei_flush) begin
            state <= S_IDLE;
          end else begin
            req_line <= aligned;
            if (ibus_req && ibus_gnt) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fencei_flush) begin
            // A response landing in the flush cycle closes the transaction.
            state <= ibus_rvalid ? S_IDLE : S_DISCARD;
          end else if (ibus_rvalid) begin
            if (req_line != aligned) req_line <= aligned;
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (ibus_rvalid) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
